// File: rtl/inst_decode.sv
// Instruction decode stage: 32x32 register file with write-through bypass,
// decode of the supported ALU subset, and the registered ID/EX boundary.
module inst_decode #(
  parameter int          RF_DEPTH = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic [3:0]  id_alu_op,
  output logic        id_alu_src_imm,
  output logic        id_reg_write,
  output logic        id_ovf_chk,
  output logic        id_illegal
);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_ADDU = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SUBU = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];

  logic [4:0]  rs_addr_s;
  logic [4:0]  rt_addr_s;
  logic [4:0]  rd_addr_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [15:0] imm16_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;

  logic [31:0] dec_imm_s;
  logic [4:0]  dec_dest_s;
  logic [3:0]  dec_alu_op_s;
  logic        dec_src_imm_s;
  logic        dec_reg_write_s;
  logic        dec_ovf_chk_s;
  logic        dec_illegal_s;

  logic [31:0] pc_d, pc_q;
  logic [31:0] rs_data_d, rs_data_q;
  logic [31:0] rt_data_d, rt_data_q;
  logic [31:0] imm_d, imm_q;
  logic [4:0]  dest_d, dest_q;
  logic [3:0]  alu_op_d, alu_op_q;
  logic        src_imm_d, src_imm_q;
  logic        reg_write_d, reg_write_q;
  logic        ovf_chk_d, ovf_chk_q;
  logic        illegal_d, illegal_q;

  assign rs_addr_s = if_inst[25:21];
  assign rt_addr_s = if_inst[20:16];
  assign rd_addr_s = if_inst[15:11];
  assign opcode_s  = if_inst[31:26];
  assign funct_s   = if_inst[5:0];
  assign imm16_s   = if_inst[15:0];

  // Register-file next state; $0 is never written since wb_addr must be nonzero.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (wb_we && (wb_addr != 5'd0) && (int'(wb_addr) == i)) begin
        rf_d[i] = wb_data;
      end else begin
        rf_d[i] = rf_q[i];
      end
    end
  end

  // Register-file storage, cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Operand A read with same-cycle write-through bypass.
  always_comb begin
    rs_data_s = 32'd0;
    if (rs_addr_s == 5'd0) begin
      rs_data_s = 32'd0;
    end else if (wb_we && (wb_addr == rs_addr_s)) begin
      rs_data_s = wb_data;
    end else if (int'(rs_addr_s) < RF_DEPTH) begin
      rs_data_s = rf_q[rs_addr_s];
    end else begin
      rs_data_s = 32'd0;
    end
  end

  // Operand B read with same-cycle write-through bypass.
  always_comb begin
    rt_data_s = 32'd0;
    if (rt_addr_s == 5'd0) begin
      rt_data_s = 32'd0;
    end else if (wb_we && (wb_addr == rt_addr_s)) begin
      rt_data_s = wb_data;
    end else if (int'(rt_addr_s) < RF_DEPTH) begin
      rt_data_s = rf_q[rt_addr_s];
    end else begin
      rt_data_s = 32'd0;
    end
  end

  // Instruction decode; unsupported encodings leave everything but illegal at 0.
  always_comb begin
    dec_imm_s       = 32'd0;
    dec_dest_s      = 5'd0;
    dec_alu_op_s    = ALU_AND;
    dec_src_imm_s   = 1'b0;
    dec_reg_write_s = 1'b0;
    dec_ovf_chk_s   = 1'b0;
    dec_illegal_s   = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        if (if_inst == 32'd0) begin
          dec_illegal_s = 1'b0;
        end else begin
          dec_dest_s      = rd_addr_s;
          dec_reg_write_s = 1'b1;
          case (funct_s)
            6'b100100: dec_alu_op_s = ALU_AND;
            6'b100101: dec_alu_op_s = ALU_OR;
            6'b100110: dec_alu_op_s = ALU_XOR;
            6'b100111: dec_alu_op_s = ALU_NOR;
            6'b100000: begin
              dec_alu_op_s  = ALU_ADD;
              dec_ovf_chk_s = 1'b1;
            end
            6'b100001: dec_alu_op_s = ALU_ADDU;
            6'b100010: begin
              dec_alu_op_s  = ALU_SUB;
              dec_ovf_chk_s = 1'b1;
            end
            6'b100011: dec_alu_op_s = ALU_SUBU;
            6'b101010: dec_alu_op_s = ALU_SLT;
            default: begin
              dec_dest_s      = 5'd0;
              dec_reg_write_s = 1'b0;
              dec_illegal_s   = 1'b1;
            end
          endcase
        end
      end
      OP_ANDI: begin
        dec_alu_op_s    = ALU_AND;
        dec_dest_s      = rt_addr_s;
        dec_imm_s       = {16'h0000, imm16_s};
        dec_src_imm_s   = 1'b1;
        dec_reg_write_s = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_op_s    = ALU_ADD;
        dec_dest_s      = rt_addr_s;
        dec_imm_s       = {{16{imm16_s[15]}}, imm16_s};
        dec_src_imm_s   = 1'b1;
        dec_reg_write_s = 1'b1;
        dec_ovf_chk_s   = 1'b1;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // ID/EX next state: flush beats stall, stall holds everything.
  always_comb begin
    pc_d        = pc_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    dest_d      = dest_q;
    alu_op_d    = alu_op_q;
    src_imm_d   = src_imm_q;
    reg_write_d = reg_write_q;
    ovf_chk_d   = ovf_chk_q;
    illegal_d   = illegal_q;
    if (flush) begin
      pc_d        = RESET_PC;
      rs_data_d   = 32'd0;
      rt_data_d   = 32'd0;
      imm_d       = 32'd0;
      dest_d      = 5'd0;
      alu_op_d    = 4'd0;
      src_imm_d   = 1'b0;
      reg_write_d = 1'b0;
      ovf_chk_d   = 1'b0;
      illegal_d   = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d        = if_pc;
      rs_data_d   = rs_data_s;
      rt_data_d   = rt_data_s;
      imm_d       = dec_imm_s;
      dest_d      = dec_dest_s;
      alu_op_d    = dec_alu_op_s;
      src_imm_d   = dec_src_imm_s;
      reg_write_d = dec_reg_write_s;
      ovf_chk_d   = dec_ovf_chk_s;
      illegal_d   = dec_illegal_s;
    end
  end

  // ID/EX pipeline registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      imm_q       <= 32'd0;
      dest_q      <= 5'd0;
      alu_op_q    <= 4'd0;
      src_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      ovf_chk_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      dest_q      <= dest_d;
      alu_op_q    <= alu_op_d;
      src_imm_q   <= src_imm_d;
      reg_write_q <= reg_write_d;
      ovf_chk_q   <= ovf_chk_d;
      illegal_q   <= illegal_d;
    end
  end

  assign id_pc          = pc_q;
  assign id_rs_data     = rs_data_q;
  assign id_rt_data     = rt_data_q;
  assign id_imm         = imm_q;
  assign id_dest        = dest_q;
  assign id_alu_op      = alu_op_q;
  assign id_alu_src_imm = src_imm_q;
  assign id_reg_write   = reg_write_q;
  assign id_ovf_chk     = ovf_chk_q;
  assign id_illegal     = illegal_q;

endmodule

// File: tb/tb_inst_decode.sv
// Directed self-checking bench for inst_decode with hand-computed expectations.
module tb_inst_decode;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        flush;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] id_pc;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm;
  logic        id_reg_write;
  logic        id_ovf_chk;
  logic        id_illegal;

  int n_checks;
  int n_pass;

  logic [5:0] fn_tab  [9] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2a};
  logic [3:0] op_tab  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic       ovf_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  inst_decode dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .flush          (flush),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .id_pc          (id_pc),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_dest        (id_dest),
    .id_alu_op      (id_alu_op),
    .id_alu_src_imm (id_alu_src_imm),
    .id_reg_write   (id_reg_write),
    .id_ovf_chk     (id_ovf_chk),
    .id_illegal     (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    if_pc    = 32'd0;
    if_inst  = 32'd0;
    wb_we    = 1'b0;
    wb_addr  = 5'd0;
    wb_data  = 32'd0;

    // Reset state
    repeat (2) step();
    check_eq("rst_pc", id_pc, 32'h0000_0000);
    check_eq("rst_dest", {27'd0, id_dest}, 32'd0);
    check_eq("rst_rw", {31'd0, id_reg_write}, 32'd0);
    rstn = 1'b1;

    // and $3,$1,$2 right after reset
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'b100100);
    if_pc   = 32'h0000_0000;
    step();
    check_eq("and_rs", id_rs_data, 32'd0);
    check_eq("and_rt", id_rt_data, 32'd0);
    check_eq("and_pc", id_pc, 32'd0);
    check_eq("and_dest", {27'd0, id_dest}, 32'd3);
    check_eq("and_rw", {31'd0, id_reg_write}, 32'd1);

    // Write $4 then read it back through the register file
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0055;
    if_inst = 32'd0;
    step();
    wb_we = 1'b0;
    if_inst = rtype(5'd4, 5'd0, 5'd7, 6'b100101);
    if_pc   = 32'h0000_0008;
    step();
    check_eq("rd4_rs", id_rs_data, 32'h0000_0055);
    check_eq("rd4_pc", id_pc, 32'h0000_0008);

    // Asynchronous reset mid-cycle clears outputs and register file
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_rs", id_rs_data, 32'd0);
    check_eq("arst_pc", id_pc, 32'd0);
    check_eq("arst_dest", {27'd0, id_dest}, 32'd0);
    check_eq("arst_rw", {31'd0, id_reg_write}, 32'd0);
    #1;
    rstn = 1'b1;
    step();
    check_eq("arst_rf4", id_rs_data, 32'd0);
    check_eq("arst_dest7", {27'd0, id_dest}, 32'd7);

    // add $3,$1,$2 with same-cycle bypass of $1
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0007;
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    if_pc   = 32'h0000_0010;
    step();
    check_eq("add_rs_byp", id_rs_data, 32'h0000_0007);
    check_eq("add_op", {28'd0, id_alu_op}, 32'd4);
    check_eq("add_dest", {27'd0, id_dest}, 32'd3);
    check_eq("add_ovf", {31'd0, id_ovf_chk}, 32'd1);
    check_eq("add_rw", {31'd0, id_reg_write}, 32'd1);
    check_eq("add_pc", id_pc, 32'h0000_0010);

    // andi / addi immediates
    wb_we = 1'b0;
    if_inst = itype(6'b001100, 5'd1, 5'd2, 16'hFFFF);
    step();
    check_eq("andi_imm", id_imm, 32'h0000_FFFF);
    check_eq("andi_op", {28'd0, id_alu_op}, 32'd0);
    check_eq("andi_src", {31'd0, id_alu_src_imm}, 32'd1);
    check_eq("andi_dest", {27'd0, id_dest}, 32'd2);
    check_eq("andi_rs", id_rs_data, 32'h0000_0007);
    check_eq("andi_ovf", {31'd0, id_ovf_chk}, 32'd0);
    if_inst = itype(6'b001000, 5'd1, 5'd2, 16'hFFFB);
    step();
    check_eq("addi_imm", id_imm, 32'hFFFF_FFFB);
    check_eq("addi_op", {28'd0, id_alu_op}, 32'd4);
    check_eq("addi_ovf", {31'd0, id_ovf_chk}, 32'd1);
    check_eq("addi_src", {31'd0, id_alu_src_imm}, 32'd1);

    // Write to $0 discarded, $0 reads zero even when targeted by wb
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    if_inst = rtype(5'd0, 5'd0, 5'd3, 6'b100101);
    step();
    check_eq("r0_byp_rs", id_rs_data, 32'd0);
    check_eq("r0_op", {28'd0, id_alu_op}, 32'd1);
    wb_we = 1'b0;
    if_inst = 32'd0;
    step();
    check_eq("nop_rs", id_rs_data, 32'd0);
    check_eq("nop_rw", {31'd0, id_reg_write}, 32'd0);
    check_eq("nop_ill", {31'd0, id_illegal}, 32'd0);
    check_eq("nop_dest", {27'd0, id_dest}, 32'd0);

    // sub with bypass on operand B
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0022;
    if_inst = rtype(5'd1, 5'd2, 5'd6, 6'b100010);
    step();
    check_eq("sub_rt_byp", id_rt_data, 32'h0000_0022);
    check_eq("sub_rs", id_rs_data, 32'h0000_0007);
    check_eq("sub_src", {31'd0, id_alu_src_imm}, 32'd0);
    wb_we = 1'b0;

    // All supported R-type functs
    for (int k = 0; k < 9; k++) begin
      if_inst = rtype(5'd1, 5'd2, 5'd9, fn_tab[k]);
      step();
      check_eq($sformatf("rt_op%0d", k), {28'd0, id_alu_op}, {28'd0, op_tab[k]});
      check_eq($sformatf("rt_ovf%0d", k), {31'd0, id_ovf_chk}, {31'd0, ovf_tab[k]});
      check_eq($sformatf("rt_imm%0d", k), id_imm, 32'd0);
    end

    // slt then a 3-cycle stall while writing $5
    if_inst = rtype(5'd1, 5'd2, 5'd8, 6'b101010);
    if_pc   = 32'h0000_0020;
    step();
    check_eq("slt_op", {28'd0, id_alu_op}, 32'd8);
    stall = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0009;
    if_inst = rtype(5'd5, 5'd5, 5'd9, 6'b100000);
    if_pc   = 32'h0000_0024;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("stl_op%0d", k), {28'd0, id_alu_op}, 32'd8);
      check_eq($sformatf("stl_dest%0d", k), {27'd0, id_dest}, 32'd8);
      check_eq($sformatf("stl_pc%0d", k), id_pc, 32'h0000_0020);
      check_eq($sformatf("stl_ovf%0d", k), {31'd0, id_ovf_chk}, 32'd0);
    end
    stall = 1'b0;
    wb_we = 1'b0;
    if_inst = rtype(5'd5, 5'd0, 5'd10, 6'b100101);
    if_pc   = 32'h0000_0028;
    step();
    check_eq("post_stl_rs", id_rs_data, 32'h0000_0009);
    check_eq("post_stl_dest", {27'd0, id_dest}, 32'd10);

    // Flush beats stall
    stall = 1'b1; flush = 1'b1;
    step();
    check_eq("fl_rw", {31'd0, id_reg_write}, 32'd0);
    check_eq("fl_pc", id_pc, 32'd0);
    check_eq("fl_rs", id_rs_data, 32'd0);
    check_eq("fl_dest", {27'd0, id_dest}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Illegal opcode: controls cleared, operands/PC still registered
    if_inst = itype(6'b100011, 5'd1, 5'd2, 16'h0004);
    if_pc   = 32'h0000_0030;
    step();
    check_eq("ill_flag", {31'd0, id_illegal}, 32'd1);
    check_eq("ill_rw", {31'd0, id_reg_write}, 32'd0);
    check_eq("ill_dest", {27'd0, id_dest}, 32'd0);
    check_eq("ill_rs", id_rs_data, 32'h0000_0007);
    check_eq("ill_pc", id_pc, 32'h0000_0030);

    // Unsupported R-type funct
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'b000000);
    step();
    check_eq("ill_fn_flag", {31'd0, id_illegal}, 32'd1);
    check_eq("ill_fn_rw", {31'd0, id_reg_write}, 32'd0);
    check_eq("ill_fn_dest", {27'd0, id_dest}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
